// File: rtl/shot_aim_controller_pkg.sv
// Shared types and default tuning constants for the shot aim controller.
package billiard_aim_pkg;

   localparam int unsigned VEL_W_DEF         = 11;
   localparam int unsigned VEL_LIMIT_DEF     = 200;
   localparam int unsigned STEP_SLOW_DEF     = 1;
   localparam int unsigned STEP_FAST_DEF     = 4;
   localparam int unsigned ACCEL_FRAMES_DEF  = 16;
   localparam int unsigned SETTLE_FRAMES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      AIM       = 2'd1,
      FIRE      = 2'd2,
      WAIT_STOP = 2'd3
   } aim_state_t;

endpackage

// File: rtl/shot_aim_controller_if.sv
// Keypad/frame inputs and velocity handoff outputs of the shot aim controller.
interface shot_aim_if
   import billiard_aim_pkg::*;
#(
   parameter int unsigned VEL_W = VEL_W_DEF
);
   logic                    drawLine;
   logic                    startOfFrame;
   logic                    ballsStopped;
   logic                    key2IsPressed;
   logic                    key8IsPressed;
   logic                    key4IsPressed;
   logic                    key6IsPressed;
   logic                    keyEnterIsPressed;
   logic signed [VEL_W-1:0] newVelocityX;
   logic signed [VEL_W-1:0] newVelocityY;
   logic                    velocityWriteEnable;
   logic                    aimActive;

   modport master (
      output drawLine, startOfFrame, ballsStopped,
      output key2IsPressed, key8IsPressed, key4IsPressed, key6IsPressed, keyEnterIsPressed,
      input  newVelocityX, newVelocityY, velocityWriteEnable, aimActive
   );

   modport slave (
      input  drawLine, startOfFrame, ballsStopped,
      input  key2IsPressed, key8IsPressed, key4IsPressed, key6IsPressed, keyEnterIsPressed,
      output newVelocityX, newVelocityY, velocityWriteEnable, aimActive
   );
endinterface

// File: rtl/shot_aim_controller_axis.sv
// One aim axis: key-hold acceleration counter, step select and saturating velocity.
module aim_axis_stepper
   import billiard_aim_pkg::*;
#(
   parameter int unsigned VEL_W        = VEL_W_DEF,
   parameter int unsigned VEL_LIMIT    = VEL_LIMIT_DEF,
   parameter int unsigned STEP_SLOW    = STEP_SLOW_DEF,
   parameter int unsigned STEP_FAST    = STEP_FAST_DEF,
   parameter int unsigned ACCEL_FRAMES = ACCEL_FRAMES_DEF
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_inc,
   input  logic                    i_dec,
   input  logic                    i_tick,
   input  logic                    i_clear,
   output logic signed [VEL_W-1:0] o_vel,
   output logic signed [VEL_W-1:0] o_next_c
);
   localparam int unsigned CNT_W = $clog2(ACCEL_FRAMES + 1);
   localparam int unsigned SUM_W = VEL_W + 1;
   localparam logic signed [SUM_W-1:0] LIM_P = SUM_W'(VEL_LIMIT);
   localparam logic signed [SUM_W-1:0] LIM_N = -LIM_P;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACCEL_FRAMES);

   logic signed [VEL_W-1:0] r_vel;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [1:0]       r_dir;

   logic signed [1:0]       w_dir;
   logic [CNT_W-1:0]        w_cnt_eff;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic signed [SUM_W-1:0] w_step;
   logic signed [SUM_W-1:0] w_sum;
   logic signed [VEL_W-1:0] w_clamp;

   // A reversal restarts the hold count so the first reversed frame is a slow step.
   always_comb begin
      w_dir = 2'sd0;
      if (i_inc && !i_dec)      w_dir = 2'sd1;
      else if (i_dec && !i_inc) w_dir = -2'sd1;

      w_cnt_eff = (w_dir == r_dir) ? r_cnt : '0;
      if (w_dir == 2'sd0)            w_cnt_nxt = '0;
      else if (w_cnt_eff >= CNT_MAX) w_cnt_nxt = CNT_MAX;
      else                           w_cnt_nxt = w_cnt_eff + CNT_W'(1);

      w_step = (w_cnt_eff >= CNT_MAX) ? SUM_W'(STEP_FAST) : SUM_W'(STEP_SLOW);
      w_sum  = {r_vel[VEL_W-1], r_vel};
      if (w_dir == 2'sd1)       w_sum = w_sum + w_step;
      else if (w_dir == -2'sd1) w_sum = w_sum - w_step;

      w_clamp = w_sum[VEL_W-1:0];
      if (w_sum > LIM_P)      w_clamp = LIM_P[VEL_W-1:0];
      else if (w_sum < LIM_N) w_clamp = LIM_N[VEL_W-1:0];

      o_next_c = r_vel;
      if (i_clear)     o_next_c = '0;
      else if (i_tick) o_next_c = w_clamp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vel <= '0;
         r_cnt <= '0;
         r_dir <= 2'sd0;
      end else if (i_clear) begin
         r_vel <= '0;
         r_cnt <= '0;
         r_dir <= 2'sd0;
      end else if (i_tick) begin
         r_vel <= w_clamp;
         r_cnt <= w_cnt_nxt;
         r_dir <= w_dir;
      end
   end

   assign o_vel = r_vel;

endmodule

// File: rtl/shot_aim_controller.sv
// Keypad aim to shot velocity: aim FSM, Enter edge detect and settle timer around two axis steppers.
module shot_aim_controller
   import billiard_aim_pkg::*;
#(
   parameter int unsigned VEL_W         = VEL_W_DEF,
   parameter int unsigned VEL_LIMIT     = VEL_LIMIT_DEF,
   parameter int unsigned STEP_SLOW     = STEP_SLOW_DEF,
   parameter int unsigned STEP_FAST     = STEP_FAST_DEF,
   parameter int unsigned ACCEL_FRAMES  = ACCEL_FRAMES_DEF,
   parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF
)(
   input  logic     clk,
   input  logic     reset,
   shot_aim_if.slave bus
);
   localparam int unsigned SET_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
   localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_FRAMES);

   aim_state_t        r_state;
   aim_state_t        w_state_nxt;
   logic              r_enter_prev;
   logic              r_we;
   logic              r_aim;
   logic [SET_W-1:0]  r_settle;

   logic                    w_fire;
   logic                    w_clear;
   logic                    w_tick;
   logic signed [VEL_W-1:0] w_vel_x;
   logic signed [VEL_W-1:0] w_vel_y;
   logic signed [VEL_W-1:0] w_next_x;
   logic signed [VEL_W-1:0] w_next_y;

   assign w_fire  = bus.startOfFrame && bus.keyEnterIsPressed && !r_enter_prev;
   assign w_clear = (r_state != AIM) || !bus.drawLine;
   assign w_tick  = bus.startOfFrame && (r_state == AIM);

   aim_axis_stepper #(
      .VEL_W(VEL_W), .VEL_LIMIT(VEL_LIMIT), .STEP_SLOW(STEP_SLOW),
      .STEP_FAST(STEP_FAST), .ACCEL_FRAMES(ACCEL_FRAMES)
   ) u_axis_x (
      .clk(clk), .rst(reset), .i_inc(bus.key6IsPressed), .i_dec(bus.key4IsPressed),
      .i_tick(w_tick), .i_clear(w_clear), .o_vel(w_vel_x), .o_next_c(w_next_x)
   );

   aim_axis_stepper #(
      .VEL_W(VEL_W), .VEL_LIMIT(VEL_LIMIT), .STEP_SLOW(STEP_SLOW),
      .STEP_FAST(STEP_FAST), .ACCEL_FRAMES(ACCEL_FRAMES)
   ) u_axis_y (
      .clk(clk), .rst(reset), .i_inc(bus.key2IsPressed), .i_dec(bus.key8IsPressed),
      .i_tick(w_tick), .i_clear(w_clear), .o_vel(w_vel_y), .o_next_c(w_next_y)
   );

   // Fire decision looks at post-step velocities so the shot never carries a zero vector.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:      if (bus.drawLine && bus.ballsStopped) w_state_nxt = AIM;
         AIM: begin
            if (!bus.drawLine)
               w_state_nxt = IDLE;
            else if (w_fire && ((w_next_x != '0) || (w_next_y != '0)))
               w_state_nxt = FIRE;
         end
         FIRE:      w_state_nxt = WAIT_STOP;
         WAIT_STOP: if ((r_settle >= SETTLE_MAX) && bus.ballsStopped) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_enter_prev <= 1'b0;
         r_we         <= 1'b0;
         r_aim        <= 1'b0;
         r_settle     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= (w_state_nxt == FIRE);
         r_aim   <= (w_state_nxt == AIM);
         if (bus.startOfFrame) r_enter_prev <= bus.keyEnterIsPressed;
         if (r_state != WAIT_STOP)
            r_settle <= '0;
         else if (bus.startOfFrame && (r_settle < SETTLE_MAX))
            r_settle <= r_settle + SET_W'(1);
      end
   end

   assign bus.newVelocityX        = w_vel_x;
   assign bus.newVelocityY        = w_vel_y;
   assign bus.velocityWriteEnable = r_we;
   assign bus.aimActive           = r_aim;

endmodule

// File: tb/tb_shot_aim_controller.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor compares them.
module tb_shot_aim_controller;
   import billiard_aim_pkg::*;

   localparam int unsigned VW = VEL_W_DEF;

   typedef struct {
      logic signed [VW-1:0] x;
      logic signed [VW-1:0] y;
      logic                 aim;
      logic                 we;
      string                tag;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic probe = 1'b0;
   logic pend  = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_we     = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   shot_aim_if #(.VEL_W(VW)) bus ();

   shot_aim_controller #(.VEL_W(VW)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // A frame strobe or a probe marks the following cycle as one the DUT presents a result in.
   always @(posedge clk) pend <= bus.startOfFrame | probe;
   always @(posedge clk) if (bus.velocityWriteEnable === 1'b1) n_we = n_we + 1;

   always @(negedge clk) begin
      exp_t e;
      if (pend) begin
         n_checks = n_checks + 1;
         if (q.size() == 0) begin
            $display("FAIL unexpected_sample: got x=%0d y=%0d, no expectation queued",
                     bus.newVelocityX, bus.newVelocityY);
         end else begin
            e = q.pop_front();
            if (bus.newVelocityX === e.x && bus.newVelocityY === e.y &&
                bus.aimActive === e.aim && bus.velocityWriteEnable === e.we)
               n_pass = n_pass + 1;
            else
               $display("FAIL %s: got x=%0d y=%0d aim=%0b we=%0b, want x=%0d y=%0d aim=%0b we=%0b",
                        e.tag, bus.newVelocityX, bus.newVelocityY, bus.aimActive,
                        bus.velocityWriteEnable, e.x, e.y, e.aim, e.we);
         end
      end
   end

   task automatic push(input int ex, input int ey, input bit ea, input bit ew, input string tag);
      q.push_back('{VW'(ex), VW'(ey), ea, ew, tag});
   endtask

   task automatic keys(input bit k2, input bit k8, input bit k4, input bit k6, input bit ent);
      bus.key2IsPressed     = k2;
      bus.key8IsPressed     = k8;
      bus.key4IsPressed     = k4;
      bus.key6IsPressed     = k6;
      bus.keyEnterIsPressed = ent;
   endtask

   // One frame strobe plus one quiet cycle; called on a negedge, returns on a negedge.
   task automatic frame(input bit k2, input bit k8, input bit k4, input bit k6, input bit ent,
                        input int ex, input int ey, input bit ea, input bit ew, input string tag);
      keys(k2, k8, k4, k6, ent);
      bus.startOfFrame = 1'b1;
      push(ex, ey, ea, ew, tag);
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      @(negedge clk);
   endtask

   task automatic sample(input int ex, input int ey, input bit ea, input bit ew, input string tag);
      probe = 1'b1;
      push(ex, ey, ea, ew, tag);
      @(negedge clk);
      probe = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reenter();
      bus.drawLine = 1'b0;
      idle(2);
      sample(0, 0, 1'b0, 1'b0, "idle_clear");
      bus.drawLine = 1'b1;
      idle(2);
      sample(0, 0, 1'b1, 1'b0, "reaim");
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      int ey;
      bus.drawLine     = 1'b0;
      bus.startOfFrame = 1'b0;
      bus.ballsStopped = 1'b1;
      keys(0, 0, 0, 0, 0);
      @(negedge clk);
      idle(2);
      reset = 1'b0;
      sample(0, 0, 1'b0, 1'b0, "reset_state");
      bus.drawLine = 1'b1;
      idle(2);
      sample(0, 0, 1'b1, 1'b0, "enter_aim");

      // Acceleration on X
      for (int i = 1; i <= 20; i++)
         frame(0, 0, 0, 1, 0, (i <= 16) ? i : 16 + 4 * (i - 16), 0, 1'b1, 1'b0, "accel_x");
      frame(0, 0, 0, 0, 0, 32, 0, 1'b1, 1'b0, "accel_release");
      reenter();

      // Negative clamp on Y, then slow step after release
      for (int i = 1; i <= 100; i++) begin
         ey = (i <= 16) ? -i : -16 - 4 * (i - 16);
         if (ey < -200) ey = -200;
         frame(0, 1, 0, 0, 0, 0, ey, 1'b1, 1'b0, "clamp_neg");
      end
      frame(0, 0, 0, 0, 0, 0, -200, 1'b1, 1'b0, "clamp_release");
      frame(1, 0, 0, 0, 0, 0, -199, 1'b1, 1'b0, "clamp_slow_up");
      reenter();

      // Opposite keys cancel
      for (int i = 1; i <= 7; i++) frame(0, 0, 0, 1, 0, i, 0, 1'b1, 1'b0, "opp_setup");
      for (int i = 0; i < 10; i++) frame(0, 0, 1, 1, 0, 7, 0, 1'b1, 1'b0, "opp_both");
      frame(0, 0, 0, 1, 0, 8, 0, 1'b1, 1'b0, "opp_release4");
      reenter();

      // Zero-velocity fire and Enter held across entry into AIM
      frame(0, 0, 0, 0, 1, 0, 0, 1'b1, 1'b0, "zero_fire");
      frame(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, "zero_fire_after");
      bus.drawLine = 1'b0;
      idle(2);
      frame(0, 0, 0, 0, 1, 0, 0, 1'b0, 1'b0, "idle_enter");
      bus.drawLine = 1'b1;
      idle(2);
      frame(0, 0, 0, 1, 1, 1, 0, 1'b1, 1'b0, "held_enter");
      frame(0, 0, 0, 0, 0, 1, 0, 1'b1, 1'b0, "held_enter_after");
      reenter();

      // Shot handoff and settle before re-aim
      for (int i = 1; i <= 5; i++) frame(0, 0, 0, 1, 0, i, 0, 1'b1, 1'b0, "shot_x");
      for (int i = 1; i <= 3; i++) frame(0, 1, 0, 0, 0, 5, -i, 1'b1, 1'b0, "shot_y");
      keys(0, 0, 0, 0, 1);
      bus.startOfFrame = 1'b1;
      push(5, -3, 1'b0, 1'b1, "shot_fire");
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      probe = 1'b1;
      push(0, 0, 1'b0, 1'b0, "post_shot");
      @(negedge clk);
      probe = 1'b0;
      frame(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, "settle1");
      idle(3);
      sample(0, 0, 1'b0, 1'b0, "settle1_hold");
      frame(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, "settle2");
      idle(2);
      sample(0, 0, 1'b1, 1'b0, "settle_reaim");

      // Reset during the FIRE cycle
      frame(0, 0, 0, 1, 0, 1, 0, 1'b1, 1'b0, "pre_reset");
      frame(0, 0, 0, 1, 0, 2, 0, 1'b1, 1'b0, "pre_reset");
      keys(0, 0, 0, 0, 1);
      bus.startOfFrame = 1'b1;
      push(0, 0, 1'b0, 1'b0, "reset_in_fire");
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      keys(0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      sample(0, 0, 1'b1, 1'b0, "after_reset");

      // drawLine drop beats an Enter edge in the same frame
      frame(0, 0, 0, 1, 0, 1, 0, 1'b1, 1'b0, "pre_drop");
      bus.drawLine = 1'b0;
      frame(0, 0, 0, 0, 1, 0, 0, 1'b0, 1'b0, "drop_vs_fire");
      sample(0, 0, 1'b0, 1'b0, "drop_idle");

      idle(4);
      n_checks = n_checks + 1;
      if (n_we == 1) n_pass = n_pass + 1;
      else $display("FAIL write_count: got %0d pulses, want 1", n_we);
      n_checks = n_checks + 1;
      if (q.size() == 0) n_pass = n_pass + 1;
      else $display("FAIL queue_drain: got %0d unchecked expectations, want 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
